// File: rtl/register_memory_unit.sv
// register_memory_unit: unified program/data memory, instruction register and register file of the fetch/storage core.
module register_memory_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] MemData,
  input  logic              MoveEnable,
  input  logic              RegWrite,
  input  logic              InstWrite,
  output logic [DATA_W-1:0] MemOut,
  output logic [DATA_W-1:0] RegOutA,
  output logic [DATA_W-1:0] RegOutB,
  output logic [REG_AW-1:0] Rm,
  output logic              MoveA,
  output logic              MoveB
);
  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};
  logic [DATA_W-1:0] regFile [2**REG_AW];
  logic [DATA_W-1:0] ir;
  logic [REG_AW-1:0] rA, rB;
  assign rA = ir[3*REG_AW-1:2*REG_AW];
  assign rB = ir[2*REG_AW-1:REG_AW];
  assign Rm = ir[REG_AW-1:0];
  assign MemOut = mem[Address];
  assign RegOutA = regFile[rA];
  assign RegOutB = regFile[rB];
  assign MoveA = MoveEnable && (rA == Rm);
  assign MoveB = MoveEnable && (rB == Rm);
  // memory is never cleared by reset, only protected from writes while it is held
  always_ff @(posedge CLK)
    if (!Reset && !InstWrite) mem[Address] <= MemData;
  always_ff @(posedge CLK)
    if (Reset) begin
      ir <= '0;
      regFile <= '{default: '0};
    end else begin
      if (InstWrite) ir <= MemOut;
      if (RegWrite) regFile[rA] <= MemOut;
    end
endmodule

// File: tb/tb_register_memory_unit.sv
// tb_register_memory_unit: directed checks of memory, IR fetch, register writes, move flags and reset.
module tb_register_memory_unit;
  logic        CLK = 1'b0;
  logic        Reset;
  logic [9:0]  Address;
  logic [15:0] MemData;
  logic        MoveEnable, RegWrite, InstWrite;
  logic [15:0] MemOut, RegOutA, RegOutB;
  logic [3:0]  Rm;
  logic        MoveA, MoveB;
  int total = 0;
  int bad = 0;

  register_memory_unit dut (
    .CLK(CLK), .Reset(Reset), .Address(Address), .MemData(MemData),
    .MoveEnable(MoveEnable), .RegWrite(RegWrite), .InstWrite(InstWrite),
    .MemOut(MemOut), .RegOutA(RegOutA), .RegOutB(RegOutB), .Rm(Rm),
    .MoveA(MoveA), .MoveB(MoveB)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; InstWrite = 1'b1; RegWrite = 1'b1; MoveEnable = 1'b0;
    Address = '0; MemData = '0;
    step(); step();
    chk("rst_regA", RegOutA, 16'h0000);
    chk("rst_regB", RegOutB, 16'h0000);
    chk("rst_rm", Rm, 4'h0);
    chk("rst_moveA", MoveA, 1'b0);
    chk("rst_moveB", MoveB, 1'b0);
    chk("rst_mem0", MemOut, 16'h0000);
    MoveEnable = 1'b1; #1;
    chk("rst_moveA_en", MoveA, 1'b1);
    chk("rst_moveB_en", MoveB, 1'b1);
    MoveEnable = 1'b0;
    Reset = 1'b0; RegWrite = 1'b0; InstWrite = 1'b0;
    Address = 10'd1; MemData = 16'h1234; step();
    chk("wr_visible_after_edge", MemOut, 16'h1234);
    Address = 10'd2; MemData = 16'h0F0F; step();
    Address = 10'd3; MemData = 16'h0215; step();
    Address = 10'd4; MemData = 16'h0535; step();
    InstWrite = 1'b1; Address = 10'd1; #1;
    chk("rd_mem1", MemOut, 16'h1234);
    Address = 10'd2; #1;
    chk("rd_mem2", MemOut, 16'h0F0F);
    Address = 10'd0; #1;
    chk("rd_mem0", MemOut, 16'h0000);
    Address = 10'd3; step();
    chk("fetch3_rm", Rm, 4'h5);
    chk("fetch3_moveA_off", MoveA, 1'b0);
    chk("fetch3_moveB_off", MoveB, 1'b0);
    MoveEnable = 1'b1; #1;
    chk("fetch3_moveA_on", MoveA, 1'b0);
    chk("fetch3_moveB_on", MoveB, 1'b0);
    Address = 10'd4; step();
    chk("fetch4_rm", Rm, 4'h5);
    chk("fetch4_moveA", MoveA, 1'b1);
    chk("fetch4_moveB", MoveB, 1'b0);
    MoveEnable = 1'b0; #1;
    chk("fetch4_moveA_off", MoveA, 1'b0);
    chk("fetch4_moveB_off", MoveB, 1'b0);
    InstWrite = 1'b0; Address = 10'd1; MemData = 16'h1234; RegWrite = 1'b1; step();
    chk("regwr_regA", RegOutA, 16'h1234);
    chk("regwr_regB", RegOutB, 16'h0000);
    chk("regwr_ir_held", Rm, 4'h5);
    chk("regwr_mem1", MemOut, 16'h1234);
    InstWrite = 1'b1; Address = 10'd2; step();
    chk("oldrA_rm", Rm, 4'hF);
    chk("oldrA_regA", RegOutA, 16'h0000);
    RegWrite = 1'b0; Address = 10'd4; step();
    chk("oldrA_reg5", RegOutA, 16'h0F0F);
    Reset = 1'b1; RegWrite = 1'b1; InstWrite = 1'b1; Address = 10'd1; step();
    chk("midrst_rm", Rm, 4'h0);
    chk("midrst_regA", RegOutA, 16'h0000);
    InstWrite = 1'b0; MemData = 16'hFFFF; step();
    chk("midrst_mem1_kept", MemOut, 16'h1234);
    Reset = 1'b0; RegWrite = 1'b0; InstWrite = 1'b1; Address = 10'd4; step();
    chk("postrst_rm", Rm, 4'h5);
    chk("postrst_reg5", RegOutA, 16'h0000);
    Address = 10'd1; #1;
    chk("postrst_mem1", MemOut, 16'h1234);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_memory_unit.md
Name: register_memory_unit

Overview:
- Fetch/storage core of the 16-bit processor datapath. It contains a 1024x16 unified memory, an instruction register (IR) and a 16x16 register file.
- Each cycle it operates in one of two modes, selected by InstWrite:
  - Program mode (InstWrite=0): the memory is loaded from MemData.
  - Fetch mode (InstWrite=1): instructions are fetched into IR.
- IR fields drive the register-file read ports, the Rm field output and the move-match flags MoveA/MoveB, which feed the downstream ALU/move logic.

Parameters:
- ADDR_W, 10, memory address width; depth = 2**ADDR_W words.
- DATA_W, 16, memory, IR and register word width.
- REG_AW, 4, register index width; 16 registers.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Address  input  10  memory word address for read and write.
- MemData  input  16  memory write data (program mode).
- MoveEnable  input  1  qualifies MoveA/MoveB.
- RegWrite  input  1  register-file write enable.
- InstWrite  input  1  1 = fetch mode (IR load); 0 = program mode (memory write).
- MemOut  output  16  asynchronous read of mem[Address].
- RegOutA  output  16  asynchronous read of reg[IR[11:8]].
- RegOutB  output  16  asynchronous read of reg[IR[7:4]].
- Rm  output  4  IR[3:0].
- MoveA  output  1  MoveEnable & (IR[11:8] == IR[3:0]).
- MoveB  output  1  MoveEnable & (IR[7:4] == IR[3:0]).

Behaviour:
- IR field layout: [15:12] opcode (unused here), [11:8] rA, [7:4] rB, [3:0] Rm.
- Memory:
  - All words are zero at power-up (initialised at elaboration). Reset does NOT clear memory.
  - Read is combinational: MemOut = mem[Address]. MemOut updates in the same cycle Address changes.
  - Write: on a rising edge with InstWrite=0 and Reset=0, mem[Address] <= MemData.
  - MemOut shows the new value after that edge (no read-during-write bypass within the cycle).
- IR:
  - On a rising edge with InstWrite=1 and Reset=0, IR <= mem[Address] (the pre-edge MemOut).
  - IR holds when InstWrite=0.
- Register file:
  - On a rising edge with RegWrite=1 and Reset=0, reg[IR[11:8]] <= MemOut.
  - The index and data are sampled before the edge. When IR loads on the same edge, the write uses the old IR's rA.
  - RegWrite is independent of InstWrite: both may act on one edge.
  - Reads are combinational; a written value appears on RegOutA/RegOutB after the edge. All 16 registers are writable, with no hardwired zero.
- Outputs Rm, MoveA and MoveB are purely combinational from IR and MoveEnable. MoveA and MoveB are 0 whenever MoveEnable=0.
- Reset (synchronous, highest priority):
  - IR <= 0 and all 16 registers <= 0. All writes are suppressed that edge.
  - After reset: Rm=0, RegOutA=RegOutB=0. MoveA=MoveB=MoveEnable, since all fields are 0 and therefore equal.
  - Reset asserted mid-operation overrides any InstWrite/RegWrite on that edge. Memory contents are retained.
- Address is always in range (10 bits), so no wrap logic is required.
- No handshake; every operation completes in one cycle. Latency: memory/IR/register writes take 1 cycle; reads take 0 cycles.

Test Plan:
- Power-up and reset: assert Reset for 2 edges with InstWrite=1 and RegWrite=1 -> RegOutA=RegOutB=0, Rm=0, MoveA=MoveB=0 with MoveEnable=0. MemOut=0 at Address=0.
- Program and read back: InstWrite=0, write 16'h1234 to Address 1 and 16'h0F0F to Address 2 on successive edges. Then set InstWrite=1 and Address=1 -> MemOut=16'h1234 with no clock needed; mem[0] is still 0.
- Fetch and fields: mem[3]=16'h0215. Fetch from Address 3 with InstWrite=1 -> after the edge, Rm=4'h5. With MoveEnable=0, MoveA=MoveB=0. With MoveEnable=1, MoveA=0 (2≠5) and MoveB=0 (1≠5).
- Move match: mem[4]=16'h0535, fetched, MoveEnable=1 -> MoveA=1, MoveB=0, Rm=5. Drop MoveEnable -> both flags 0 in the same cycle.
- Register write:
  - With IR=16'h0535, InstWrite=0 (IR holds), Address=1 and RegWrite=1, one edge -> reg[5]=16'h1234.
  - RegOutA=16'h1234 after the edge; RegOutB=reg[3]=0.
  - Because InstWrite=0 on that edge, mem[1] is also overwritten by MemData. Set MemData=16'h1234 for this check.
- Reset mid-run: after the above, assert Reset with RegWrite=1 and InstWrite=1 -> IR=0 and reg[5]=0 (RegOutA=0). mem[1] is still 16'h1234.
